// File: rtl/spn_pkg.sv
// Shared definitions for the iterative SPN block cipher core:
// S-box tables, FSM state encoding, permutation index helpers and
// round-key derivation.
package spn_pkg;

    // Widest block the helper functions are built to handle
    localparam int MAXW = 256;

    // Round counter width; covers the full 1..255 round range
    localparam int CNTW = 8;

    // Forward and inverse 4-bit S-boxes, entry n at bits [4n+3:4n]
    localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } spn_state_e;

    function automatic logic [3:0] spn_sbox(input logic [3:0] n);
        return SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] spn_inv_sbox(input logic [3:0] n);
        return INV_SBOX[{n, 2'b00} +: 4];
    endfunction

    // Destination of input bit i under the forward permutation P
    function automatic int spn_p_idx(input int i, input int dataw);
        int res;
        if (i == dataw - 1) begin
            res = i;
        end else begin
            res = (i * (dataw / 4)) % (dataw - 1);
        end
        return res;
    endfunction

    // Destination of input bit j under P^-1. Since 4*(dataw/4) == 1
    // modulo (dataw-1), multiplying by 4 undoes the forward step.
    function automatic int spn_p_inv_idx(input int j, input int dataw);
        int res;
        if (j == dataw - 1) begin
            res = j;
        end else begin
            res = (4 * j) % (dataw - 1);
        end
        return res;
    endfunction

    // rk[r] = rotl(key, (r*krot) mod dataw) ^ r, within dataw bits
    function automatic logic [MAXW-1:0] spn_round_key(
        input logic [MAXW-1:0] key,
        input int              r,
        input int              dataw,
        input int              krot
    );
        logic [MAXW-1:0] rot;
        logic [MAXW-1:0] rz;
        int              sh;
        rot = {MAXW{1'b0}};
        rz  = {MAXW{1'b0}};
        sh  = (r * krot) % dataw;
        for (int b = 0; b < dataw; b++) begin
            rot[(b + sh) % dataw] = key[b];
        end
        rz[7:0] = 8'(r);
        return rot ^ rz;
    endfunction

endpackage

// File: rtl/spn_round_step.sv
// One SPN round, purely combinational.
// Forward:  P(S(data ^ rk)).
// Inverse:  S^-1(P^-1(data)) ^ rk  (only built with SPN_DECRYPT_EN).
module spn_round_step #(
    parameter int DATAW = 32
) (
    input  logic [DATAW-1:0] data_i,
    input  logic [DATAW-1:0] rk_i,
    input  logic             dir_i,
    output logic [DATAW-1:0] data_o
);
    import spn_pkg::*;

    logic [DATAW-1:0] mix_s;
    logic [DATAW-1:0] sub_s;
    logic [DATAW-1:0] enc_s;

    // Forward round: key mix, nibble substitution, bit permutation
    always_comb begin
        mix_s = data_i ^ rk_i;
        sub_s = {DATAW{1'b0}};
        for (int n = 0; n < DATAW / 4; n++) begin
            sub_s[4*n +: 4] = spn_sbox(mix_s[4*n +: 4]);
        end
        enc_s = {DATAW{1'b0}};
        for (int i = 0; i < DATAW; i++) begin
            enc_s[spn_p_idx(i, DATAW)] = sub_s[i];
        end
    end

`ifdef SPN_DECRYPT_EN
    logic [DATAW-1:0] pinv_s;
    logic [DATAW-1:0] dec_s;

    // Inverse round: undo permutation, undo substitution, key mix
    always_comb begin
        pinv_s = {DATAW{1'b0}};
        for (int j = 0; j < DATAW; j++) begin
            pinv_s[spn_p_inv_idx(j, DATAW)] = data_i[j];
        end
        dec_s = {DATAW{1'b0}};
        for (int n = 0; n < DATAW / 4; n++) begin
            dec_s[4*n +: 4] = spn_inv_sbox(pinv_s[4*n +: 4]);
        end
        dec_s = dec_s ^ rk_i;
    end

    // Direction select
    always_comb begin
        if (dir_i) begin
            data_o = dec_s;
        end else begin
            data_o = enc_s;
        end
    end
`else
    logic unused_dir_s;
    assign unused_dir_s = dir_i;
    assign data_o       = enc_s;
`endif

endmodule

// File: rtl/spn_iter_core.sv
// Iterative SPN block cipher core: one round per clock, handshake in
// and out, result held until the consumer takes it.
// Optional feature macro: SPN_DECRYPT_EN adds the inverse (decrypt)
// path selected by mode_i=1; without it mode_i is ignored.
module spn_iter_core #(
    parameter int DATAW   = 32,
    parameter int NROUNDS = 8,
    parameter int KROT    = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DATAW-1:0] ptext_i,
    input  logic [DATAW-1:0] key_i,
    input  logic             mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DATAW-1:0] cipher_o,
    output logic             busy_o
);
    import spn_pkg::*;

    spn_state_e       state_r;
    spn_state_e       state_nx_s;
    logic [CNTW-1:0]  cnt_r;
    logic [DATAW-1:0] data_r;
    logic [DATAW-1:0] key_r;
    logic [DATAW-1:0] cipher_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    logic             accept_s;
    logic             first_s;
    logic             last_s;
    int               rnd_idx_s;
    logic             dir_s;
    logic [DATAW-1:0] rk_round_s;
    logic [DATAW-1:0] rk_final_s;
    logic [DATAW-1:0] step_in_s;
    logic [DATAW-1:0] step_out_s;
    logic [DATAW-1:0] result_s;

`ifdef SPN_DECRYPT_EN
    logic             mode_r;
`else
    logic             unused_mode_s;
    assign unused_mode_s = mode_i;
`endif

    assign accept_s = in_valid_i & in_ready_r;
    assign first_s  = (cnt_r == {CNTW{1'b0}});
    assign last_s   = (cnt_r == CNTW'(NROUNDS - 1));

    // Pick the round index and direction for the round executed this edge
    always_comb begin
        rnd_idx_s = int'(cnt_r);
        dir_s     = 1'b0;
`ifdef SPN_DECRYPT_EN
        if (mode_r) begin
            rnd_idx_s = NROUNDS - 1 - int'(cnt_r);
            dir_s     = 1'b1;
        end else begin
            rnd_idx_s = int'(cnt_r);
            dir_s     = 1'b0;
        end
`endif
    end

    assign rk_round_s = DATAW'(spn_round_key(MAXW'(key_r), rnd_idx_s, DATAW, KROT));
    assign rk_final_s = DATAW'(spn_round_key(MAXW'(key_r), NROUNDS, DATAW, KROT));

    // Final-key whitening ahead of the first inverse round
    always_comb begin
        step_in_s = data_r;
`ifdef SPN_DECRYPT_EN
        if (mode_r && first_s) begin
            step_in_s = data_r ^ rk_final_s;
        end else begin
            step_in_s = data_r;
        end
`endif
    end

    spn_round_step #(
        .DATAW (DATAW)
    ) u_round_step (
        .data_i (step_in_s),
        .rk_i   (rk_round_s),
        .dir_i  (dir_s),
        .data_o (step_out_s)
    );

    // Final-key whitening after the last forward round
    always_comb begin
        result_s = step_out_s;
`ifdef SPN_DECRYPT_EN
        if (!mode_r && last_s) begin
            result_s = step_out_s ^ rk_final_s;
        end else begin
            result_s = step_out_s;
        end
`else
        if (last_s) begin
            result_s = step_out_s ^ rk_final_s;
        end else begin
            result_s = step_out_s;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: accept in IDLE, iterate in RUN, wait for consumer in DONE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state so outputs come off flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    // Request latch, round iteration and result capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r    <= {CNTW{1'b0}};
            data_r   <= {DATAW{1'b0}};
            key_r    <= {DATAW{1'b0}};
            cipher_r <= {DATAW{1'b0}};
`ifdef SPN_DECRYPT_EN
            mode_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        data_r <= ptext_i;
                        key_r  <= key_i;
                        cnt_r  <= {CNTW{1'b0}};
`ifdef SPN_DECRYPT_EN
                        mode_r <= mode_i;
`endif
                    end
                end
                ST_RUN: begin
                    data_r <= result_s;
                    if (last_s) begin
                        cnt_r    <= {CNTW{1'b0}};
                        cipher_r <= result_s;
                    end else begin
                        cnt_r    <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    cnt_r <= {CNTW{1'b0}};
                end
                default: begin
                    cnt_r <= {CNTW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign busy_o      = busy_r;
    assign cipher_o    = cipher_r;

endmodule

// File: tb/tb_spn_iter_core.sv
// Randomized self-checking bench for spn_iter_core. Two instances:
// a 32-bit / 8-round core and a 64-bit / 1-round core. Expected
// results come from a word-level reference model of the cipher.
module tb_spn_iter_core;

    localparam int W0 = 32;
    localparam int N0 = 8;
    localparam int K0 = 7;
    localparam int W1 = 64;
    localparam int N1 = 1;
    localparam int K1 = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  mode;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  busy;
    logic [63:0] ptext [2];
    logic [63:0] key   [2];
    logic [31:0] cipher0;
    logic [63:0] cipher1;
    logic [63:0] prev_res [2];

    int n_checks = 0;
    int n_errors = 0;

    int sb_tab [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    always #5 clk = ~clk;

    spn_iter_core #(.DATAW(W0), .NROUNDS(N0), .KROT(K0)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .ptext_i(ptext[0][31:0]), .key_i(key[0][31:0]), .mode_i(mode[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .cipher_o(cipher0), .busy_o(busy[0])
    );

    spn_iter_core #(.DATAW(W1), .NROUNDS(N1), .KROT(K1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .ptext_i(ptext[1]), .key_i(key[1]), .mode_i(mode[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .cipher_o(cipher1), .busy_o(busy[1])
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cipher_of(input int w);
        return (w == 1) ? cipher1 : {32'h0, cipher0};
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] one;
        one = 64'd1;
        if (w >= 64) return ~64'd0;
        else return (one << w) - 64'd1;
    endfunction

    // Round key: rotate left inside w bits, then xor the round number
    function automatic logic [63:0] m_rk(input logic [63:0] k, input int r, input int w, input int kr);
        int          sh;
        logic [63:0] rot;
        sh = (r * kr) % w;
        if (sh == 0) rot = k;
        else rot = ((k << sh) | (k >> (w - sh))) & wmask(w);
        return rot ^ 64'(r);
    endfunction

    // Reference encryption built directly from the round definition
    function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [63:0] k_in,
                                               input int w, input int n, input int kr);
        logic [63:0] x;
        logic [63:0] k;
        logic [63:0] s;
        logic [63:0] p;
        int          dst;
        k = k_in & wmask(w);
        x = pt & wmask(w);
        for (int r = 0; r < n; r++) begin
            x = x ^ m_rk(k, r, w, kr);
            s = 64'd0;
            for (int j = 0; j < w / 4; j++) s[4*j +: 4] = 4'(sb_tab[x[4*j +: 4]]);
            p = 64'd0;
            for (int i = 0; i < w; i++) begin
                dst = (i == w - 1) ? i : (i * w / 4) % (w - 1);
                p[dst] = s[i];
            end
            x = p;
        end
        return x ^ m_rk(k, n, w, kr);
    endfunction

    function automatic logic [63:0] enc_of(input int w, input logic [63:0] pt, input logic [63:0] k);
        return (w == 1) ? model_enc(pt, k, W1, N1, K1) : model_enc(pt, k, W0, N0, K0);
    endfunction

    // One transaction, entered and left at a falling edge. Inputs are
    // scrambled while busy; the result is held for 'hold' cycles.
    task automatic do_block(input int w, input logic [63:0] pt, input logic [63:0] k,
                            input logic md, input logic [63:0] exp, input int hold);
        int lat;
        int nr;
        nr = (w == 1) ? N1 : N0;
        chk_eq("accept_ready", 64'(in_ready[w]), 64'd1);
        in_valid[w] = 1'b1;
        ptext[w]    = pt;
        key[w]      = k;
        mode[w]     = md;
        @(negedge clk);
        in_valid[w] = 1'b0;
        chk_eq("run_busy", 64'(busy[w]), 64'd1);
        chk_eq("run_not_ready", 64'(in_ready[w]), 64'd0);
        chk_eq("run_cipher_held", cipher_of(w), prev_res[w]);
        lat = 0;
        while (out_valid[w] !== 1'b1 && lat < 400) begin
            in_valid[w] = 1'($urandom);
            ptext[w]    = {$urandom, $urandom};
            key[w]      = {$urandom, $urandom};
            mode[w]     = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk_eq("latency", 64'(lat), 64'(nr));
        chk_eq("result", cipher_of(w), exp);
        for (int h = 0; h < hold; h++) begin
            in_valid[w] = 1'($urandom);
            ptext[w]    = {$urandom, $urandom};
            @(negedge clk);
            chk_eq("hold_valid", 64'(out_valid[w]), 64'd1);
            chk_eq("hold_cipher", cipher_of(w), exp);
        end
        // Request present on the DONE->IDLE edge must not be taken
        in_valid[w]  = 1'b1;
        out_ready[w] = 1'b1;
        @(negedge clk);
        in_valid[w]  = 1'b0;
        out_ready[w] = 1'b0;
        chk_eq("idle_valid", 64'(out_valid[w]), 64'd0);
        chk_eq("idle_ready", 64'(in_ready[w]), 64'd1);
        chk_eq("idle_busy", 64'(busy[w]), 64'd0);
        chk_eq("idle_cipher", cipher_of(w), exp);
        prev_res[w] = exp;
    endtask

    initial begin
        logic [63:0] pt;
        logic [63:0] k;
        logic [63:0] r0;
        logic        md;
        int          w;

        in_valid    = 2'b00;
        out_ready   = 2'b00;
        mode        = 2'b00;
        ptext[0]    = 64'd0;
        ptext[1]    = 64'd0;
        key[0]      = 64'd0;
        key[1]      = 64'd0;
        prev_res[0] = 64'd0;
        prev_res[1] = 64'd0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk_eq("rst_ready", 64'(in_ready[d]), 64'd1);
            chk_eq("rst_valid", 64'(out_valid[d]), 64'd0);
            chk_eq("rst_busy", 64'(busy[d]), 64'd0);
            chk_eq("rst_cipher", cipher_of(d), 64'd0);
        end
        rst = 1'b0;

        // Directed vector, accepted on the first edge after reset
        do_block(0, 64'h1234_5678, 64'h0F1E_2D3C, 1'b0,
                 enc_of(0, 64'h1234_5678, 64'h0F1E_2D3C), 0);

        // Long backpressure
        pt = 64'hCAFE_F00D;
        k  = 64'h1357_9BDF;
        do_block(0, pt, k, 1'b0, enc_of(0, pt, k), 20);

        // Randomized blocks on both widths
        for (int i = 0; i < 16; i++) begin
            w  = i % 2;
            pt = {$urandom, $urandom} & wmask(w == 1 ? W1 : W0);
            k  = {$urandom, $urandom} & wmask(w == 1 ? W1 : W0);
`ifdef SPN_DECRYPT_EN
            md = 1'b0;
`else
            md = 1'($urandom);
`endif
            do_block(w, pt, k, md, enc_of(w, pt, k), int'($urandom_range(0, 3)));
        end

`ifdef SPN_DECRYPT_EN
        // Encrypt then decrypt recovers the plaintext
        for (int d = 0; d < 2; d++) begin
            pt = 64'hDEAD_BEEF;
            k  = 64'hA5A5_A5A5;
            r0 = enc_of(d, pt, k);
            do_block(d, pt, k, 1'b0, r0, 1);
            do_block(d, r0, k, 1'b1, pt, 0);
            pt = {$urandom, $urandom} & wmask(d == 1 ? W1 : W0);
            k  = {$urandom, $urandom} & wmask(d == 1 ? W1 : W0);
            r0 = enc_of(d, pt, k);
            do_block(d, pt, k, 1'b0, r0, 0);
            do_block(d, r0, k, 1'b1, pt, 2);
        end
`else
        // Mode is ignored: decrypt request still encrypts
        for (int d = 0; d < 2; d++) begin
            pt = 64'hDEAD_BEEF;
            k  = 64'hA5A5_A5A5;
            r0 = enc_of(d, pt, k);
            do_block(d, pt, k, 1'b1, r0, 0);
            do_block(d, pt, k, 1'b0, r0, 0);
        end
`endif

        // Reset in the middle of a run
        in_valid[0] = 1'b1;
        ptext[0]    = 64'h0BAD_CAFE;
        key[0]      = 64'h7777_1111;
        mode[0]     = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("mid_run_busy", 64'(busy[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_eq("arst_valid", 64'(out_valid[0]), 64'd0);
        chk_eq("arst_ready", 64'(in_ready[0]), 64'd1);
        chk_eq("arst_busy", 64'(busy[0]), 64'd0);
        chk_eq("arst_cipher", cipher_of(0), 64'd0);
        chk_eq("arst_cipher1", cipher_of(1), 64'd0);
        prev_res[0] = 64'd0;
        prev_res[1] = 64'd0;
        @(negedge clk);
        rst = 1'b0;
        pt = 64'h0BAD_CAFE;
        k  = 64'h7777_1111;
        do_block(0, pt, k, 1'b0, enc_of(0, pt, k), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
